// File: rtl/enc_dec_pkg.sv
// Shared definitions for the 3-to-8 decoder and its companion 8-to-3 encoder.
package enc_dec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    function automatic logic [ONEHOT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder38_comb.sv
// Purely combinational 3-to-8 one-hot decode.
module decoder38_comb
    import enc_dec_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    assign onehot = onehot8(code);

endmodule

// File: rtl/decoder38_dwell.sv
// Sequential 3-to-8 decoder: each accepted code is shown one-hot for DWELL
// enabled cycles; a single pending slot lets codes stream without idle gaps.
//
// state | meaning
// IDLE  | nothing displayed, oData = 0, ready for a code whenever enabled
// SHOW  | oData holds a one-hot pattern, dwell counter running down to 0
module decoder38_dwell
    import enc_dec_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iEn,
    input  logic                iValid,
    input  logic [CODE_W-1:0]   iData,
    output logic                oReady,
    output logic [ONEHOT_W-1:0] oData,
    output logic                oValid,
    output logic                oDone
);

    // A DWELL of 0 would never show anything, so it behaves as 1.
    localparam int DW = (DWELL < 1) ? 1 : DWELL;
    localparam int CNT_W = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CODE_W-1:0]     pend_code;
    logic                  pend_full;
    logic [ONEHOT_W-1:0]   data_q;
    logic [CODE_W-1:0]     sel_code;
    logic [ONEHOT_W-1:0]   dec_onehot;
    logic                  xfer;
    logic                  last;

    // The pending slot only fills while in SHOW, so whenever it is empty the
    // decoder sees the incoming code (first load from IDLE, or a bypass).
    assign sel_code = pend_full ? pend_code : iData;

    decoder38_comb u_dec (
        .code   (sel_code),
        .onehot (dec_onehot)
    );

    assign oReady = iRst_n & iEn & ((state == IDLE) | ~pend_full);
    assign xfer   = iValid & oReady;
    assign last   = (state == SHOW) & iEn & (cnt == '0);
    assign oDone  = last;
    assign oValid = (state == SHOW);
    assign oData  = data_q;

    // FSM, dwell counter, pending slot and output register; all frozen when iEn=0.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_code <= '0;
            pend_full <= 1'b0;
            data_q    <= '0;
        end else if (iEn) begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state  <= SHOW;
                        data_q <= dec_onehot;
                        cnt    <= CNT_LOAD;
                    end
                end
                SHOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (xfer) begin
                            pend_code <= iData;
                            pend_full <= 1'b1;
                        end
                    end else if (pend_full) begin
                        data_q    <= dec_onehot;
                        cnt       <= CNT_LOAD;
                        pend_full <= 1'b0;
                    end else if (xfer) begin
                        data_q <= dec_onehot;
                        cnt    <= CNT_LOAD;
                    end else begin
                        state  <= IDLE;
                        data_q <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    data_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder38_dwell.sv
// Bench for decoder38_dwell: DWELL=4 and DWELL=1 instances checked against a
// display-sequence model every cycle, plus directed literal checks.
module tb_decoder38_dwell;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en4 = 1'b1, valid4 = 1'b0;
    logic [2:0] data4 = '0;
    logic       ready4, ovalid4, done4;
    logic [7:0] odata4;

    logic       en1 = 1'b1, valid1 = 1'b0;
    logic [2:0] data1 = '0;
    logic       ready1, ovalid1, done1;
    logic [7:0] odata1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decoder38_dwell #(.DWELL(4)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iEn(en4), .iValid(valid4), .iData(data4),
        .oReady(ready4), .oData(odata4), .oValid(ovalid4), .oDone(done4)
    );

    decoder38_dwell #(.DWELL(1)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iEn(en1), .iValid(valid1), .iData(data1),
        .oReady(ready1), .oData(odata1), .oValid(ovalid1), .oDone(done1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: which code is on display, how many enabled cycles it has been
    // shown, and the one code waiting behind it (-1 = none).
    typedef struct {
        int cur;
        int shown;
        int pend;
        int d;
    } model_t;

    model_t m4 = '{cur: -1, shown: 0, pend: -1, d: 4};
    model_t m1 = '{cur: -1, shown: 0, pend: -1, d: 1};

    function automatic bit m_ready(model_t m, bit rst, bit en);
        return rst && en && (m.cur < 0 || m.pend < 0);
    endfunction

    function automatic bit m_done(model_t m, bit en);
        return m.cur >= 0 && en && m.shown == m.d - 1;
    endfunction

    function automatic logic [7:0] m_data(model_t m);
        logic [7:0] one;
        one = 8'd1;
        return (m.cur < 0) ? 8'h00 : (one << m.cur);
    endfunction

    function automatic model_t m_step(model_t m, bit en, bit valid, logic [2:0] code);
        bit xfer;
        xfer = valid && m_ready(m, 1'b1, en);
        if (!en) return m;
        if (m.cur < 0) begin
            if (xfer) begin
                m.cur = int'(code);
                m.shown = 0;
            end
            return m;
        end
        m.shown++;
        if (m.shown == m.d) begin
            if (m.pend >= 0) begin
                m.cur = m.pend;
                m.pend = -1;
            end else if (xfer) begin
                m.cur = int'(code);
            end else begin
                m.cur = -1;
            end
            m.shown = 0;
        end else if (xfer) begin
            m.pend = int'(code);
        end
        return m;
    endfunction

    // Per-cycle compare of both instances against the model, then advance it.
    always @(negedge clk) begin
        if (!rst_n) begin
            m4 = '{cur: -1, shown: 0, pend: -1, d: 4};
            m1 = '{cur: -1, shown: 0, pend: -1, d: 1};
        end
        chk("m4_ready", 8'(ready4), 8'(m_ready(m4, rst_n, en4)));
        chk("m4_data", odata4, m_data(m4));
        chk("m4_valid", 8'(ovalid4), 8'(m4.cur >= 0));
        chk("m4_done", 8'(done4), 8'(m_done(m4, en4)));
        chk("m1_ready", 8'(ready1), 8'(m_ready(m1, rst_n, en1)));
        chk("m1_data", odata1, m_data(m1));
        chk("m1_valid", 8'(ovalid1), 8'(m1.cur >= 0));
        chk("m1_done", 8'(done1), 8'(m_done(m1, en1)));
        if (rst_n) begin
            m4 = m_step(m4, en4, valid4, data4);
            m1 = m_step(m1, en1, valid1, data1);
        end
    end

    // Encoder round-trip scoreboard for the DWELL=1 instance.
    int sb_codes[$];

    function automatic int encode8(input logic [7:0] v, output int ones);
        int idx;
        idx = -1;
        ones = 0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) begin
                idx = b;
                ones++;
            end
        end
        return idx;
    endfunction

    always @(negedge clk) begin
        int ones;
        int code;
        if (rst_n && ovalid1) begin
            code = encode8(odata1, ones);
            chk("t5_onehot_ones", 8'(ones), 8'd1);
            chk("t5_done_each", 8'(done1), 8'd1);
            sb_codes.push_back(code);
        end
    end

    task automatic send(input int k, input logic [2:0] code, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        if (k == 0) begin valid4 = 1'b1; data4 = code; end
        else        begin valid1 = 1'b1; data1 = code; end
        while (!ok && waits < 40) begin
            @(negedge clk);
            ok = (k == 0) ? ready4 : ready1;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout actual=not_ready required=ready code=%0d", code);
        end
        if (k == 0) valid4 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int held;
        int dones;
        logic [7:0] exp_t2 [8];
        exp_t2 = '{8'h01, 8'h01, 8'h01, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00};

        // Reset state
        #2;
        chk("rst_data", odata4, 8'h00);
        chk("rst_valid", 8'(ovalid4), 8'd0);
        chk("rst_ready", 8'(ready4), 8'd0);
        chk("rst_done", 8'(done4), 8'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: single code 3
        send(0, 3'd3, w);
        chk("t1_waits", 8'(w), 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_data", odata4, 8'h08);
            chk("t1_done", 8'(done4), 8'(i == 3));
        end
        @(negedge clk);
        chk("t1_idle_data", odata4, 8'h00);
        chk("t1_idle_valid", 8'(ovalid4), 8'd0);
        settle();

        // T2: back-to-back 7, 0, 5
        send(0, 3'd7, w);
        send(0, 3'd0, w);
        chk("t2_waits_0", 8'(w), 8'd0);
        send(0, 3'd5, w);
        chk("t2_waits_5", 8'(w), 8'd3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_seq", odata4, exp_t2[i]);
        end
        settle();

        // T3: pause during code 2
        held = 0;
        dones = 0;
        send(0, 3'd2, w);
        @(negedge clk);
        if (odata4 == 8'h04) held++;
        if (done4) dones++;
        @(posedge clk);
        #1;
        en4 = 1'b0;
        valid4 = 1'b1;
        data4 = 3'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (odata4 == 8'h04) held++;
            chk("t3_pause_ready", 8'(ready4), 8'd0);
            chk("t3_pause_done", 8'(done4), 8'd0);
            @(posedge clk);
            #1;
        end
        en4 = 1'b1;
        valid4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (odata4 == 8'h04) held++;
            if (done4) dones++;
            if (odata4 == 8'h00) break;
        end
        chk("t3_held", 8'(held), 8'd7);
        chk("t3_dones", 8'(dones), 8'd1);
        settle();

        // T4: reset during SHOW with a buffered code
        send(0, 3'd1, w);
        send(0, 3'd4, w);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_data", odata4, 8'h00);
        chk("t4_async_valid", 8'(ovalid4), 8'd0);
        chk("t4_async_ready", 8'(ready4), 8'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_lost_data", odata4, 8'h00);
            chk("t4_lost_valid", 8'(ovalid4), 8'd0);
        end
        @(posedge clk);
        #1;

        // T6: bypass in last dwell cycle
        send(0, 3'd3, w);
        repeat (3) @(posedge clk);
        #1;
        valid4 = 1'b1;
        data4 = 3'd6;
        @(negedge clk);
        chk("t6_last_done", 8'(done4), 8'd1);
        chk("t6_last_ready", 8'(ready4), 8'd1);
        chk("t6_last_data", odata4, 8'h08);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        @(negedge clk);
        chk("t6_bypass_data", odata4, 8'h40);
        settle();

        // T5: DWELL=1 stream of 0..7
        sb_codes.delete();
        w = 0;
        for (int c = 0; c < 8; c++) begin
            int wc;
            send(1, 3'(c), wc);
            w += wc;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t5_waits", 8'(w), 8'd0);
        chk("t5_count", 8'(sb_codes.size()), 8'd8);
        for (int c = 0; c < 8; c++) begin
            if (c < sb_codes.size()) chk("t5_roundtrip", 8'(sb_codes[c]), 8'(c));
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
